hazard_sb: RTL and testbench
============================

Name: hazard_sb

Overview:
- Hazard unit for the 5-stage RISC-V pipeline, parametrised successor of the single-cycle forwarding/stall unit.
- Adds a register scoreboard so a variable-latency long unit (mul/div, issued from E and retired on its own write port) can run alongside the pipeline.
- Adds structural-stall control for a bounded number of outstanding long ops, a compile-time forwarding/stall-only mode, and saturating stall/flush performance counters.
- Sits between datapath and controller; drives F/D stall, D/E flush and the E-stage operand-forwarding muxes.

Parameters:
- AW, 5: register-index width; number of registers = 2**AW.
- FWD_EN, 1: 1 = full forwarding; 0 = no forwarding, stall on any E/M RAW dependency.
- MAX_OUT, 2: maximum outstanding long ops, 1..7.
- PERF_W, 32: performance-counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset_x  in  1  asynchronous, active-high reset.
- Di_rs1, Di_rs2  in  AW  decode-stage source registers.
- Di_useRs1, Di_useRs2  in  1  decode instruction actually reads rs1/rs2.
- Di_rd  in  AW  decode-stage destination register.
- Di_regWrite  in  1  decode instruction writes rd.
- Di_isLong  in  1  decode instruction is a long-unit op.
- Di_jal  in  1  decode instruction is jal.
- Ei_rs1, Ei_rs2, Ei_rd, Mi_rd, Wi_rd  in  AW  pipeline register indices.
- Ei_resultSrc, Mi_resultSrc  in  2  00 ALU, 01 load, 10 imm/PC+imm.
- Ei_regWrite, Mi_regWrite, Wi_regWrite  in  1  stage write enables.
- Ei_prePCSrc  in  2  non-zero = taken branch or jalr in E.
- Ei_longStart  in  1  long op in E dispatched this cycle, destination Ei_rd.
- Li_done  in  1  long unit retires a result this cycle.
- Li_rd  in  AW  destination of the retiring result.
- Eo_forwardIn1Src, Eo_forwardIn2Src  out  2  00 RD, 01 W result, 10 M imm, 11 M ALU.
- Fo_stall, Do_stall  out  1  hold F / D registers.
- Do_flush, Eo_flush  out  1  bubble D / E registers.
- Po_stallCycles  out  PERF_W  cycles with Do_stall=1.
- Po_flushEvents  out  PERF_W  taken branch/jalr events.
- Lo_outstanding  out  3  current long-op count.

Behaviour:
State:
- pend[2**AW]: one pending bit per register.
- cnt: 3-bit outstanding-op count.
- Two PERF_W counters.
- On reset_x=1 (asynchronous): all state cleared to 0.
- All outputs except the counters and Lo_outstanding are combinational on inputs and state.

Scoreboard:
- At a clock edge with Ei_longStart=1 and Ei_rd!=0: set pend[Ei_rd].
- At a clock edge with Li_done=1: clear pend[Li_rd].
- Set and clear of the same register in one cycle: set wins.
- Register 0 is never pending.
- cnt +1 on Ei_longStart, -1 on Li_done, unchanged when both occur in the same cycle.
- Li_done with cnt=0 is illegal; cnt holds at 0 (assertion in bench).

Stall sources (sourcematch = Di_useRsN and Di_rsN!=0 and Di_rsN equals the index):
- Load-use: Ei_resultSrc=01, Ei_regWrite, sourcematch on Ei_rd.
- RAW, FWD_EN=0 only: sourcematch on Ei_rd with Ei_regWrite, or on Mi_rd with Mi_regWrite.
- Scoreboard RAW: sourcematch on a register whose pend bit is 1.
- Scoreboard WAW: Di_regWrite, Di_rd!=0 and pend[Di_rd]=1.
- Structural: Di_isLong and (cnt + Ei_longStart - Li_done) >= MAX_OUT.
- anyStall = OR of all the above.

Control outputs:
- take = (Ei_prePCSrc != 00).
- Fo_stall = Do_stall = !take & anyStall.
- Do_flush = take | (Di_jal & !anyStall).
- Eo_flush = take | anyStall.
- A taken branch overrides every stall in the same cycle.

Forwarding, per operand, with Ei_rsN != 0:
- Ei_rsN matches Mi_rd and Mi_regWrite: result src 00 gives 11, 10 gives 10, 01 gives 00.
- Otherwise Ei_rsN matches Wi_rd and Wi_regWrite: 01.
- Otherwise: 00.
- M has priority over W.
- FWD_EN=0: both selects are constant 00.

Counters:
- Po_stallCycles increments each cycle Do_stall=1.
- Po_flushEvents increments each cycle take=1.
- Both saturate at all-ones and never wrap.

Test Plan:
- Load-use: Ei_resultSrc=01, Ei_rd=5, Ei_regWrite=1, Di_rs1=5, Di_useRs1=1 -> Fo_stall=Do_stall=Eo_flush=1 for exactly one cycle; Po_stallCycles=1.
- Forward priority: Ei_rs1=7 with Mi_rd=7 (src 00, regWrite 1) and Wi_rd=7 (regWrite 1) -> Eo_forwardIn1Src=11. Mi_resultSrc=10 -> 10. Mi_regWrite=0 -> 01. Ei_rs1=0 -> 00.
- Long op: Ei_longStart with Ei_rd=9, then decode reads x9 -> stall every cycle until Li_done with Li_rd=9. Stall deasserts the cycle after Li_done; Lo_outstanding goes 1 then 0.
- Structural limit: MAX_OUT=2, two long starts, third Di_isLong -> stall. Li_done and Ei_longStart in the same cycle -> count stays 2. Same-register set+clear -> pend stays set.
- Branch override: stall condition active and Ei_prePCSrc=01 -> Fo_stall=0, Do_flush=Eo_flush=1, Po_flushEvents+1. Di_jal during a stall -> Do_flush=0.
- FWD_EN=0 build and reset: Di_rs2=3 with Mi_rd=3, Mi_regWrite=1 -> stall, forward selects 00. Assert reset_x mid-long-op -> pend, cnt and counters 0 immediately, no stall.

Source files
------------

// File: rtl/hazard_sb_if.sv
// hazard_sb_if: bundle of all decode/execute/memory/writeback hazard signals
// exchanged between the pipeline (master) and the hazard unit (slave).
//   Di_*  decode-stage sources, destination and instruction class
//   Ei_*  execute-stage indices, result source, branch and long-op dispatch
//   Mi_*, Wi_*  memory/writeback destination and write enable
//   Li_*  long-unit retirement
//   Eo_*/Fo_*/Do_*  forwarding selects, stall and flush controls
//   Po_*  saturating performance counters, Lo_outstanding long-op count
interface hazard_sb_if #(
  parameter int AW     = 5,
  parameter int PERF_W = 32
);
  logic [AW-1:0]     Di_rs1, Di_rs2, Di_rd;
  logic              Di_useRs1, Di_useRs2, Di_regWrite, Di_isLong, Di_jal;
  logic [AW-1:0]     Ei_rs1, Ei_rs2, Ei_rd, Mi_rd, Wi_rd;
  logic [1:0]        Ei_resultSrc, Mi_resultSrc;
  logic              Ei_regWrite, Mi_regWrite, Wi_regWrite;
  logic [1:0]        Ei_prePCSrc;
  logic              Ei_longStart;
  logic              Li_done;
  logic [AW-1:0]     Li_rd;
  logic [1:0]        Eo_forwardIn1Src, Eo_forwardIn2Src;
  logic              Fo_stall, Do_stall, Do_flush, Eo_flush;
  logic [PERF_W-1:0] Po_stallCycles, Po_flushEvents;
  logic [2:0]        Lo_outstanding;

  modport master (
    output Di_rs1, Di_rs2, Di_rd, Di_useRs1, Di_useRs2, Di_regWrite, Di_isLong, Di_jal,
           Ei_rs1, Ei_rs2, Ei_rd, Mi_rd, Wi_rd, Ei_resultSrc, Mi_resultSrc,
           Ei_regWrite, Mi_regWrite, Wi_regWrite, Ei_prePCSrc, Ei_longStart, Li_done, Li_rd,
    input  Eo_forwardIn1Src, Eo_forwardIn2Src, Fo_stall, Do_stall, Do_flush, Eo_flush,
           Po_stallCycles, Po_flushEvents, Lo_outstanding
  );

  modport slave (
    input  Di_rs1, Di_rs2, Di_rd, Di_useRs1, Di_useRs2, Di_regWrite, Di_isLong, Di_jal,
           Ei_rs1, Ei_rs2, Ei_rd, Mi_rd, Wi_rd, Ei_resultSrc, Mi_resultSrc,
           Ei_regWrite, Mi_regWrite, Wi_regWrite, Ei_prePCSrc, Ei_longStart, Li_done, Li_rd,
    output Eo_forwardIn1Src, Eo_forwardIn2Src, Fo_stall, Do_stall, Do_flush, Eo_flush,
           Po_stallCycles, Po_flushEvents, Lo_outstanding
  );
endinterface

// File: rtl/hazard_sb.sv
// hazard_sb: hazard unit for the 5-stage pipeline with a register scoreboard
// for a variable-latency long unit.
//   clk      rising-edge clock
//   reset_x  asynchronous active-high reset, clears scoreboard, count, counters
//   hz       hazard_sb_if slave: pipeline indices in; stall/flush/forward
//            controls, perf counters and outstanding count out
// Scoreboard, long-op count and perf counters are the only state; every other
// output is combinational on inputs and that state.
module hazard_sb #(
  parameter int AW      = 5,
  parameter int FWD_EN  = 1,
  parameter int MAX_OUT = 2,
  parameter int PERF_W  = 32
) (
  input logic       clk,
  input logic       reset_x,
  hazard_sb_if.slave hz
);
  localparam int         NREG      = 2 ** AW;
  localparam logic [3:0] MAX_OUT_W = 4'(MAX_OUT);

  logic [NREG-1:0]   pend_q, pend_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  logic take, any_stall;
  logic load_use, raw_nofwd, sb_raw, sb_waw, structural;
  logic [3:0] cnt_after, cnt_limit;

  function automatic logic src_match(logic use_rs, logic [AW-1:0] rs, logic [AW-1:0] idx);
    return use_rs && (rs != '0) && (rs == idx);
  endfunction

  function automatic logic [1:0] fwd_sel(logic [AW-1:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (FWD_EN != 0 && rs != '0) begin
      if (rs == hz.Mi_rd && hz.Mi_regWrite) begin
        // A load still in M has no data yet; load-use stall covers it.
        case (hz.Mi_resultSrc)
          2'b00:   sel = 2'b11;
          2'b10:   sel = 2'b10;
          default: sel = 2'b00;
        endcase
      end else if (rs == hz.Wi_rd && hz.Wi_regWrite) begin
        sel = 2'b01;
      end
    end
    return sel;
  endfunction

  // Stall detection
  always_comb begin
    load_use = (hz.Ei_resultSrc == 2'b01) && hz.Ei_regWrite &&
               (src_match(hz.Di_useRs1, hz.Di_rs1, hz.Ei_rd) ||
                src_match(hz.Di_useRs2, hz.Di_rs2, hz.Ei_rd));
    raw_nofwd = (FWD_EN == 0) &&
                ((hz.Ei_regWrite && (src_match(hz.Di_useRs1, hz.Di_rs1, hz.Ei_rd) ||
                                     src_match(hz.Di_useRs2, hz.Di_rs2, hz.Ei_rd))) ||
                 (hz.Mi_regWrite && (src_match(hz.Di_useRs1, hz.Di_rs1, hz.Mi_rd) ||
                                     src_match(hz.Di_useRs2, hz.Di_rs2, hz.Mi_rd))));
    sb_raw = (hz.Di_useRs1 && hz.Di_rs1 != '0 && pend_q[hz.Di_rs1]) ||
             (hz.Di_useRs2 && hz.Di_rs2 != '0 && pend_q[hz.Di_rs2]);
    sb_waw = hz.Di_regWrite && hz.Di_rd != '0 && pend_q[hz.Di_rd];
    // cnt + start - done >= MAX_OUT, rearranged so nothing goes negative.
    cnt_after  = {1'b0, cnt_q} + {3'b000, hz.Ei_longStart};
    cnt_limit  = MAX_OUT_W + {3'b000, hz.Li_done};
    structural = hz.Di_isLong && (cnt_after >= cnt_limit);
    any_stall  = load_use | raw_nofwd | sb_raw | sb_waw | structural;
    take       = (hz.Ei_prePCSrc != 2'b00);
  end

  // Control and forwarding outputs; a taken branch overrides every stall.
  assign hz.Fo_stall         = !take && any_stall;
  assign hz.Do_stall         = !take && any_stall;
  assign hz.Do_flush         = take || (hz.Di_jal && !any_stall);
  assign hz.Eo_flush         = take || any_stall;
  assign hz.Eo_forwardIn1Src = fwd_sel(hz.Ei_rs1);
  assign hz.Eo_forwardIn2Src = fwd_sel(hz.Ei_rs2);
  assign hz.Po_stallCycles   = stall_cnt_q;
  assign hz.Po_flushEvents   = flush_cnt_q;
  assign hz.Lo_outstanding   = cnt_q;

  // Next-state logic
  always_comb begin
    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    // Clear before set so a same-cycle set on the same register wins.
    if (hz.Li_done) pend_d[hz.Li_rd] = 1'b0;
    if (hz.Ei_longStart && hz.Ei_rd != '0) pend_d[hz.Ei_rd] = 1'b1;
    pend_d[0] = 1'b0;

    case ({hz.Ei_longStart, hz.Li_done})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase

    if (hz.Do_stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + PERF_W'(1);
    if (take && flush_cnt_q != '1)        flush_cnt_d = flush_cnt_q + PERF_W'(1);
  end

  // State register
  always_ff @(posedge clk or posedge reset_x) begin
    if (reset_x) begin
      // NOTE: the pending bits are a plain flop vector, not a RAM, so they are reset like any other state.
      pend_q      <= '0;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_sb.sv
// tb_hazard_sb: drives one stimulus stream into a forwarding build (ha/dut_fw)
// and a stall-only build with 4-bit counters (hb/dut_nf), comparing both
// against a behavioural model of the scoreboard, stall rules and counters.
module tb_hazard_sb;
  localparam int MAX_OUT = 2;

  logic clk = 1'b0;
  logic reset_x = 1'b1;
  always #5 clk = ~clk;

  hazard_sb_if #(.AW(5), .PERF_W(32)) ha ();
  hazard_sb_if #(.AW(5), .PERF_W(4))  hb ();

  hazard_sb #(.AW(5), .FWD_EN(1), .MAX_OUT(MAX_OUT), .PERF_W(32))
    dut_fw (.clk(clk), .reset_x(reset_x), .hz(ha));
  hazard_sb #(.AW(5), .FWD_EN(0), .MAX_OUT(MAX_OUT), .PERF_W(4))
    dut_nf (.clk(clk), .reset_x(reset_x), .hz(hb));

  assign hb.Di_rs1 = ha.Di_rs1;             assign hb.Di_rs2 = ha.Di_rs2;
  assign hb.Di_rd = ha.Di_rd;               assign hb.Di_useRs1 = ha.Di_useRs1;
  assign hb.Di_useRs2 = ha.Di_useRs2;       assign hb.Di_regWrite = ha.Di_regWrite;
  assign hb.Di_isLong = ha.Di_isLong;       assign hb.Di_jal = ha.Di_jal;
  assign hb.Ei_rs1 = ha.Ei_rs1;             assign hb.Ei_rs2 = ha.Ei_rs2;
  assign hb.Ei_rd = ha.Ei_rd;               assign hb.Mi_rd = ha.Mi_rd;
  assign hb.Wi_rd = ha.Wi_rd;               assign hb.Ei_resultSrc = ha.Ei_resultSrc;
  assign hb.Mi_resultSrc = ha.Mi_resultSrc; assign hb.Ei_regWrite = ha.Ei_regWrite;
  assign hb.Mi_regWrite = ha.Mi_regWrite;   assign hb.Wi_regWrite = ha.Wi_regWrite;
  assign hb.Ei_prePCSrc = ha.Ei_prePCSrc;   assign hb.Ei_longStart = ha.Ei_longStart;
  assign hb.Li_done = ha.Li_done;           assign hb.Li_rd = ha.Li_rd;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit    pend_m[32];
  int    cnt_m;
  longint sc_a, fc_a, sc_b, fc_b;
  localparam longint SAT_A = 64'hFFFF_FFFF;
  localparam longint SAT_B = 15;
  bit    st_a, st_b, tk;

  task automatic model_reset();
    foreach (pend_m[i]) pend_m[i] = 1'b0;
    cnt_m = 0; sc_a = 0; fc_a = 0; sc_b = 0; fc_b = 0;
  endtask

  function automatic bit sm(bit u, int rs, int idx);
    return u && rs != 0 && rs == idx;
  endfunction

  function automatic bit model_stall(bit fwd);
    int r1, r2, erd, mrd;
    bit u1, u2, s;
    r1 = int'(ha.Di_rs1); r2 = int'(ha.Di_rs2); u1 = ha.Di_useRs1; u2 = ha.Di_useRs2;
    erd = int'(ha.Ei_rd); mrd = int'(ha.Mi_rd);
    s = 1'b0;
    if (ha.Ei_resultSrc == 2'b01 && ha.Ei_regWrite && (sm(u1, r1, erd) || sm(u2, r2, erd))) s = 1'b1;
    if (!fwd && ((ha.Ei_regWrite && (sm(u1, r1, erd) || sm(u2, r2, erd))) ||
                 (ha.Mi_regWrite && (sm(u1, r1, mrd) || sm(u2, r2, mrd))))) s = 1'b1;
    if ((u1 && r1 != 0 && pend_m[r1]) || (u2 && r2 != 0 && pend_m[r2])) s = 1'b1;
    if (ha.Di_regWrite && ha.Di_rd != 0 && pend_m[ha.Di_rd]) s = 1'b1;
    if (ha.Di_isLong && (cnt_m + int'(ha.Ei_longStart) - int'(ha.Li_done) >= MAX_OUT)) s = 1'b1;
    return s;
  endfunction

  function automatic logic [1:0] model_fwd(bit fwd, int rs);
    if (!fwd || rs == 0) return 2'b00;
    if (rs == int'(ha.Mi_rd) && ha.Mi_regWrite) begin
      if (ha.Mi_resultSrc == 2'b00) return 2'b11;
      if (ha.Mi_resultSrc == 2'b10) return 2'b10;
      return 2'b00;
    end
    if (rs == int'(ha.Wi_rd) && ha.Wi_regWrite) return 2'b01;
    return 2'b00;
  endfunction

  task automatic compare();
    bit any_a, any_b;
    any_a = model_stall(1'b1);
    any_b = model_stall(1'b0);
    tk    = (ha.Ei_prePCSrc != 2'b00);
    st_a  = !tk && any_a;
    st_b  = !tk && any_b;
    check("fw_fstall", 32'(ha.Fo_stall), 32'(st_a));
    check("fw_dstall", 32'(ha.Do_stall), 32'(st_a));
    check("fw_dflush", 32'(ha.Do_flush), 32'(tk || (ha.Di_jal && !any_a)));
    check("fw_eflush", 32'(ha.Eo_flush), 32'(tk || any_a));
    check("fw_fwd1", 32'(ha.Eo_forwardIn1Src), 32'(model_fwd(1'b1, int'(ha.Ei_rs1))));
    check("fw_fwd2", 32'(ha.Eo_forwardIn2Src), 32'(model_fwd(1'b1, int'(ha.Ei_rs2))));
    check("fw_stallcnt", ha.Po_stallCycles, 32'(sc_a));
    check("fw_flushcnt", ha.Po_flushEvents, 32'(fc_a));
    check("fw_out", 32'(ha.Lo_outstanding), 32'(cnt_m));
    check("nf_dstall", 32'(hb.Do_stall), 32'(st_b));
    check("nf_fstall", 32'(hb.Fo_stall), 32'(st_b));
    check("nf_eflush", 32'(hb.Eo_flush), 32'(tk || any_b));
    check("nf_dflush", 32'(hb.Do_flush), 32'(tk || (ha.Di_jal && !any_b)));
    check("nf_fwd1", 32'(hb.Eo_forwardIn1Src), 32'd0);
    check("nf_fwd2", 32'(hb.Eo_forwardIn2Src), 32'd0);
    check("nf_stallcnt", 32'(hb.Po_stallCycles), 32'(sc_b));
    check("nf_flushcnt", 32'(hb.Po_flushEvents), 32'(fc_b));
    check("nf_out", 32'(hb.Lo_outstanding), 32'(cnt_m));
  endtask

  // Compare, advance the model across one rising edge, return at the falling edge.
  task automatic step();
    #1;
    compare();
    assert (!(ha.Li_done && cnt_m == 0)) else $error("Li_done with no outstanding long op");
    @(posedge clk);
    if (ha.Li_done) pend_m[ha.Li_rd] = 1'b0;
    if (ha.Ei_longStart && ha.Ei_rd != 0) pend_m[ha.Ei_rd] = 1'b1;
    cnt_m = cnt_m + int'(ha.Ei_longStart) - int'(ha.Li_done);
    if (cnt_m < 0) cnt_m = 0;
    if (st_a && sc_a < SAT_A) sc_a++;
    if (st_b && sc_b < SAT_B) sc_b++;
    if (tk && fc_a < SAT_A) fc_a++;
    if (tk && fc_b < SAT_B) fc_b++;
    @(negedge clk);
  endtask

  task automatic clear_in();
    ha.Di_rs1 = 0; ha.Di_rs2 = 0; ha.Di_rd = 0; ha.Di_useRs1 = 0; ha.Di_useRs2 = 0;
    ha.Di_regWrite = 0; ha.Di_isLong = 0; ha.Di_jal = 0;
    ha.Ei_rs1 = 0; ha.Ei_rs2 = 0; ha.Ei_rd = 0; ha.Mi_rd = 0; ha.Wi_rd = 0;
    ha.Ei_resultSrc = 0; ha.Mi_resultSrc = 0;
    ha.Ei_regWrite = 0; ha.Mi_regWrite = 0; ha.Wi_regWrite = 0;
    ha.Ei_prePCSrc = 0; ha.Ei_longStart = 0; ha.Li_done = 0; ha.Li_rd = 0;
  endtask

  task automatic random_in();
    int q[$];
    ha.Di_rs1 = 5'($urandom_range(0, 7)); ha.Di_rs2 = 5'($urandom_range(0, 7));
    ha.Di_rd  = 5'($urandom_range(0, 7));
    ha.Di_useRs1 = 1'($urandom); ha.Di_useRs2 = 1'($urandom);
    ha.Di_regWrite = 1'($urandom); ha.Di_isLong = ($urandom_range(0, 3) == 0);
    ha.Di_jal = ($urandom_range(0, 7) == 0);
    ha.Ei_rs1 = 5'($urandom_range(0, 7)); ha.Ei_rs2 = 5'($urandom_range(0, 7));
    ha.Ei_rd  = 5'($urandom_range(0, 7)); ha.Mi_rd = 5'($urandom_range(0, 7));
    ha.Wi_rd  = 5'($urandom_range(0, 7));
    ha.Ei_resultSrc = 2'($urandom_range(0, 2)); ha.Mi_resultSrc = 2'($urandom_range(0, 2));
    ha.Ei_regWrite = 1'($urandom); ha.Mi_regWrite = 1'($urandom); ha.Wi_regWrite = 1'($urandom);
    ha.Ei_prePCSrc = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    ha.Li_done = (cnt_m > 0) && ($urandom_range(0, 2) == 0);
    for (int i = 1; i < 32; i++) if (pend_m[i]) q.push_back(i);
    ha.Li_rd = (q.size() > 0) ? 5'(q[$urandom_range(0, q.size() - 1)]) : 5'($urandom_range(0, 7));
    ha.Ei_longStart = (cnt_m < MAX_OUT || ha.Li_done) && ($urandom_range(0, 2) == 0);
  endtask

  initial begin
    clear_in();
    model_reset();
    repeat (2) @(negedge clk);
    reset_x = 1'b0;

    // Reset state
    #1;
    check("rst_out", 32'(ha.Lo_outstanding), 32'd0);
    check("rst_stallcnt", ha.Po_stallCycles, 32'd0);
    check("rst_stall", 32'(ha.Do_stall), 32'd0);
    step();

    // Load-use: one stall cycle
    ha.Ei_resultSrc = 2'b01; ha.Ei_rd = 5; ha.Ei_regWrite = 1; ha.Di_rs1 = 5; ha.Di_useRs1 = 1;
    #1;
    check("lu_stall", 32'(ha.Do_stall), 32'd1);
    check("lu_eflush", 32'(ha.Eo_flush), 32'd1);
    step();
    clear_in();
    #1;
    check("lu_release", 32'(ha.Do_stall), 32'd0);
    check("lu_count", ha.Po_stallCycles, 32'd1);
    step();

    // Forwarding priority
    ha.Ei_rs1 = 7; ha.Mi_rd = 7; ha.Mi_regWrite = 1; ha.Mi_resultSrc = 2'b00;
    ha.Wi_rd = 7; ha.Wi_regWrite = 1;
    #1; check("fwd_m_alu", 32'(ha.Eo_forwardIn1Src), 32'd3);
    ha.Mi_resultSrc = 2'b10;
    #1; check("fwd_m_imm", 32'(ha.Eo_forwardIn1Src), 32'd2);
    ha.Mi_regWrite = 0;
    #1; check("fwd_w", 32'(ha.Eo_forwardIn1Src), 32'd1);
    ha.Ei_rs1 = 0;
    #1; check("fwd_x0", 32'(ha.Eo_forwardIn1Src), 32'd0);
    step();
    clear_in();

    // Long op on x9, decode reads x9 until retirement
    ha.Ei_longStart = 1; ha.Ei_rd = 9;
    step();
    clear_in(); ha.Di_rs1 = 9; ha.Di_useRs1 = 1;
    #1;
    check("long_stall", 32'(ha.Do_stall), 32'd1);
    check("long_out1", 32'(ha.Lo_outstanding), 32'd1);
    repeat (3) step();
    ha.Li_done = 1; ha.Li_rd = 9;
    #1; check("long_done_cycle", 32'(ha.Do_stall), 32'd1);
    step();
    ha.Li_done = 0;
    #1;
    check("long_release", 32'(ha.Do_stall), 32'd0);
    check("long_out0", 32'(ha.Lo_outstanding), 32'd0);
    step();
    clear_in();

    // Structural limit and same-register set/clear
    ha.Ei_longStart = 1; ha.Ei_rd = 10; step();
    ha.Ei_rd = 11; step();
    clear_in(); ha.Di_isLong = 1;
    #1;
    check("struct_stall", 32'(ha.Do_stall), 32'd1);
    check("struct_out2", 32'(ha.Lo_outstanding), 32'd2);
    ha.Li_done = 1; ha.Li_rd = 10; ha.Ei_longStart = 1; ha.Ei_rd = 10;
    #1; check("struct_both", 32'(ha.Do_stall), 32'd1);
    step();
    clear_in(); ha.Di_rs1 = 10; ha.Di_useRs1 = 1;
    #1;
    check("struct_hold2", 32'(ha.Lo_outstanding), 32'd2);
    check("setwins_stall", 32'(ha.Do_stall), 32'd1);
    step();
    clear_in(); ha.Li_done = 1; ha.Li_rd = 10; step();
    ha.Li_rd = 11; step();
    clear_in();

    // Branch overrides a load-use stall; jal during a stall is not flushed
    ha.Ei_resultSrc = 2'b01; ha.Ei_rd = 5; ha.Ei_regWrite = 1; ha.Di_rs1 = 5; ha.Di_useRs1 = 1;
    ha.Ei_prePCSrc = 2'b01;
    #1;
    check("br_fstall", 32'(ha.Fo_stall), 32'd0);
    check("br_dflush", 32'(ha.Do_flush), 32'd1);
    check("br_eflush", 32'(ha.Eo_flush), 32'd1);
    step();
    ha.Ei_prePCSrc = 2'b00; ha.Di_jal = 1;
    #1;
    check("br_count", ha.Po_flushEvents, 32'd1);
    check("jal_stall_noflush", 32'(ha.Do_flush), 32'd0);
    step();
    clear_in();

    // Stall-only build: M-stage RAW stalls, selects stay 00
    ha.Di_rs2 = 3; ha.Di_useRs2 = 1; ha.Mi_rd = 3; ha.Mi_regWrite = 1; ha.Ei_rs2 = 3;
    #1;
    check("nf_raw_stall", 32'(hb.Do_stall), 32'd1);
    check("fw_raw_nostall", 32'(ha.Do_stall), 32'd0);
    check("nf_raw_sel", 32'(hb.Eo_forwardIn2Src), 32'd0);
    check("fw_raw_sel", 32'(ha.Eo_forwardIn2Src), 32'd3);
    step();
    clear_in();

    // Reset in the middle of a long op
    ha.Ei_longStart = 1; ha.Ei_rd = 12; step();
    clear_in(); ha.Di_rs1 = 12; ha.Di_useRs1 = 1;
    #1; check("mid_stall", 32'(ha.Do_stall), 32'd1);
    reset_x = 1'b1;
    #1;
    check("mid_rst_out", 32'(ha.Lo_outstanding), 32'd0);
    check("mid_rst_stall", 32'(ha.Do_stall), 32'd0);
    check("mid_rst_stallcnt", ha.Po_stallCycles, 32'd0);
    check("mid_rst_flushcnt", ha.Po_flushEvents, 32'd0);
    model_reset();
    reset_x = 1'b0;
    step();
    clear_in();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      random_in();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
